// File: rtl/t_toggle_seq.sv
// T flip-flop strobe sequencer: accepts {div, cnt} jobs and pulses t every div cycles, cnt times.
// Optional qn feedback checker enabled by defining T_SEQ_FBCHK_EN.
module t_toggle_seq #(
    parameter int DIV_W = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DIV_W-1:0] div,
    input  logic [CNT_W-1:0] cnt,
    input  logic             abort,
    output logic             t,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] remaining,
    input  logic             q_fb,
    output logic             err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [DIV_W-1:0] phase_q, phase_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic             t_q, t_d;
    logic [DIV_W-1:0] div_eff;
    logic             accept;

    assign div_eff = (div == '0) ? DIV_W'(1) : div;
    assign accept  = (state_q == S_IDLE) && start;

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        div_d       = div_q;
        remaining_d = remaining_q;
        t_d         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    div_d = div_eff;
                    if (cnt == '0) begin
                        state_d     = S_DONE;
                        phase_d     = '0;
                        remaining_d = '0;
                    end else begin
                        // The acceptance cycle counts as phase 0, so the first strobe lands div_eff cycles later.
                        state_d = S_RUN;
                        if (div_eff == DIV_W'(1)) begin
                            t_d         = 1'b1;
                            phase_d     = '0;
                            remaining_d = cnt - CNT_W'(1);
                        end else begin
                            phase_d     = DIV_W'(1);
                            remaining_d = cnt;
                        end
                    end
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d     = S_IDLE;
                    phase_d     = '0;
                    remaining_d = '0;
                end else if (remaining_q == '0) begin
                    state_d = S_DONE;
                    phase_d = '0;
                end else if (phase_q == div_q - DIV_W'(1)) begin
                    t_d         = 1'b1;
                    phase_d     = '0;
                    remaining_d = remaining_q - CNT_W'(1);
                end else begin
                    phase_d = phase_q + DIV_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d     = S_IDLE;
                phase_d     = '0;
                remaining_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            phase_q     <= '0;
            div_q       <= DIV_W'(1);
            remaining_q <= '0;
            t_q         <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            div_q       <= div_d;
            remaining_q <= remaining_d;
            t_q         <= t_d;
        end
    end

    assign ready     = (state_q == S_IDLE);
    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign remaining = remaining_q;
    // An abort arriving with a due strobe suppresses it in the same cycle.
    assign t         = t_q & ~(abort & busy);

`ifdef T_SEQ_FBCHK_EN
    logic q_model_q, q_model_d;
    logic chk_q;
    logic err_q;
    logic mismatch;

    always_comb begin
        q_model_d = q_model_q;
        if (accept) begin
            q_model_d = q_fb;
        end else if (t) begin
            q_model_d = ~q_model_q;
        end
    end

    // The flop's qn settles one cycle after each strobe; compare it then and make the error sticky.
    assign mismatch = chk_q && (q_fb != q_model_q);
    assign err      = err_q | mismatch;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_model_q <= 1'b0;
            chk_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            q_model_q <= q_model_d;
            chk_q     <= t;
            err_q     <= err;
        end
    end
`else
    logic unused_fb;
    assign unused_fb = q_fb ^ accept;
    assign err       = 1'b0;
`endif

endmodule
